// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//   Request/response bundle between a requester (pipeline MEM stage) and
//   mem_access_unit.
//   master modport : the requester (drives the request, observes the response)
//   slave  modport : mem_access_unit (observes the request, drives the response)
//   Signals:
//     i_req_valid / o_req_ready   request handshake
//     i_req_write                 1 = store, 0 = load
//     i_signedmem                 sign-extend loads when 1
//     i_sizemem                   00 byte, 01 half, 10 word, 11 reserved
//     i_address                   byte address
//     i_datawrite                 right-aligned store data
//     o_resp_valid                one-cycle response pulse
//     o_dataread                  extended load result (0 for stores/errors)
//     o_misaligned                alignment error, valid with o_resp_valid
//     o_stall                     request accepted, response still pending
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic                  i_signedmem;
  logic [1:0]            i_sizemem;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_datawrite;
  logic                  o_resp_valid;
  logic [DATA_WIDTH-1:0] o_dataread;
  logic                  o_misaligned;
  logic                  o_stall;

  modport master (
    output i_req_valid, i_req_write, i_signedmem, i_sizemem, i_address, i_datawrite,
    input  o_req_ready, o_resp_valid, o_dataread, o_misaligned, o_stall
  );

  modport slave (
    input  i_req_valid, i_req_write, i_signedmem, i_sizemem, i_address, i_datawrite,
    output o_req_ready, o_resp_valid, o_dataread, o_misaligned, o_stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Data-memory stage: byte-addressed, word-organised RAM behind a valid/ready
//   request handshake. Stores commit on the acceptance edge; loads wait
//   READ_LATENCY cycles, then return a sign/zero-extended, right-aligned result
//   on a one-cycle response pulse. Misaligned or reserved-size requests return
//   o_misaligned=1 with no RAM access.
//   Ports:
//     i_clock    system clock, rising edge
//     i_reset_n  asynchronous active-low reset (RAM contents are not reset)
//     bus        mem_access_unit_if.slave request/response bundle
//   Optional (macro MEM_DEBUG_PORT_EN):
//     i_dbg_addr word index for the debug read port
//     o_dbg_data combinational read of that RAM word, usable in any state
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
`ifdef MEM_DEBUG_PORT_EN
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_dbg_addr,
  output logic [DATA_WIDTH-1:0]          o_dbg_data,
`endif
  mem_access_unit_if.slave               bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] dataread_q, dataread_d;
  logic                  misaligned_q, misaligned_d;

  logic [IDX_W-1:0]      req_idx;
  logic [1:0]            req_lane;
  logic                  req_err;
  logic                  accept;
  logic                  store_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  unused_addr_bits;

  assign req_idx  = bus.i_address[IDX_W+1:2];
  assign req_lane = bus.i_address[1:0];
  // Upper address bits are intentionally dropped so addresses wrap.
  assign unused_addr_bits = ^bus.i_address[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    req_err = 1'b0;
    case (bus.i_sizemem)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_lane[0];
      2'b10:   req_err = (req_lane != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  assign accept   = bus.i_req_valid && (state_q == S_IDLE);
  // Gate with reset so nothing commits while the unit is held in reset.
  assign store_en = accept && bus.i_req_write && !req_err && i_reset_n;

  // One RAM per byte lane: each lane has its own write enable, and the loaded
  // word is read at the registered word index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] mem [DEPTH_WORDS];
      logic       we;
      logic [7:0] wdata;

      assign we = store_en &&
                  ((bus.i_sizemem == 2'b10) ||
                   (bus.i_sizemem == 2'b01 && req_lane[1] == LANE[1]) ||
                   (bus.i_sizemem == 2'b00 && req_lane == LANE));

      // Byte stores replicate the low byte; half stores place the low half in
      // both halves; only the enabled lanes actually take the value.
      assign wdata = (bus.i_sizemem == 2'b00) ? bus.i_datawrite[7:0] :
                     (bus.i_sizemem == 2'b01) ? bus.i_datawrite[8*(gi%2) +: 8] :
                                                bus.i_datawrite[8*gi +: 8];

      always_ff @(posedge i_clock) begin
        if (we) begin
          mem[req_idx] <= wdata;
        end
      end

      assign rd_word[8*gi +: 8] = mem[idx_q];
`ifdef MEM_DEBUG_PORT_EN
      assign o_dbg_data[8*gi +: 8] = mem[i_dbg_addr];
`endif
    end
  endgenerate

  // Shift the selected lane(s) to the LSBs and extend.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b    = rd_word[{lane_q, 3'b000} +: 8];
    sel_h    = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & sel_b[7]}}, sel_b};
      2'b01:   load_ext = {{16{signed_q & sel_h[15]}}, sel_h};
      default: load_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    size_d       = size_q;
    signed_d     = signed_q;
    dataread_d   = dataread_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d        = req_idx;
          lane_d       = req_lane;
          size_d       = bus.i_sizemem;
          signed_d     = bus.i_signedmem;
          dataread_d   = '0;
          misaligned_d = req_err;
          if (req_err || bus.i_req_write) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          dataread_d = load_ext;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      idx_q        <= '0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      dataread_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      dataread_q   <= dataread_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.o_req_ready  = (state_q == S_IDLE);
  assign bus.o_stall      = (state_q == S_WAIT);
  assign bus.o_resp_valid = (state_q == S_RESP);
  assign bus.o_dataread   = (state_q == S_RESP) ? dataread_q : '0;
  assign bus.o_misaligned = (state_q == S_RESP) && misaligned_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised data-memory stage for the MIPS pipeline, successor to the single-cycle MEM stage.
- Owns a byte-addressed, word-organised data RAM.
- Accepts load/store requests over a valid/ready handshake.
- Models a configurable read latency with a state machine.
- Performs byte-lane write enables, signed/unsigned load extension and alignment checking.
- Returns results on a response pulse, and drives a stall flag toward the hazard unit.

Parameters:
DATA_WIDTH, 32, data word width in bits; fixed at 32 for byte-lane logic.
ADDR_WIDTH, 32, request address width.
DEPTH_WORDS, 256, number of RAM words; must be a power of two.
READ_LATENCY, 1, cycles between load acceptance and response; legal range 1..4.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  unit can accept a request this cycle.
i_req_write  in  1  1 = store, 0 = load.
i_signedmem  in  1  1 = sign-extend loads, 0 = zero-extend.
i_sizemem  in  2  00 byte, 01 half, 10 word, 11 reserved.
i_address  in  ADDR_WIDTH  byte address.
i_datawrite  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
o_resp_valid  out  1  one-cycle response pulse.
o_dataread  out  DATA_WIDTH  extended load result; 0 for stores and errors.
o_misaligned  out  1  error flag, valid with o_resp_valid.
o_stall  out  1  request accepted but no response yet.

Behaviour:
- Reset values (async on i_reset_n low):
  - state = IDLE, latency counter = 0.
  - o_req_ready = 1 while in IDLE.
  - o_resp_valid = 0, o_dataread = 0, o_misaligned = 0, o_stall = 0.
  - RAM contents are not reset.
- Addressing:
  - Word index = i_address[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Little-endian lanes: byte k lives at bits [8k+7:8k].
- Alignment error conditions:
  - half with address[0]=1;
  - word with address[1:0]!=0;
  - size 11.
- Handshake: a request is accepted when i_req_valid && o_req_ready. Request fields are sampled into registers on acceptance.
- State machine:
  - IDLE, o_req_ready=1:
    - Accepted error request -> RESP. No RAM write occurs.
    - Accepted store -> RAM lanes written at this clock edge -> RESP.
    - Accepted load -> WAIT with counter = READ_LATENCY-1.
  - WAIT, o_req_ready=0, o_stall=1:
    - Counter decrements each cycle.
    - When counter = 0, the RAM word is sampled, then extended and aligned -> RESP.
    - With READ_LATENCY=1, WAIT lasts exactly one cycle.
  - RESP:
    - o_resp_valid=1 for exactly one cycle, with o_dataread / o_misaligned.
    - o_req_ready=0, o_stall=0.
    - Next state IDLE.
- Latency, measured from the acceptance edge:
  - store/error response 1 cycle later;
  - load response READ_LATENCY+1 cycles later.
  - Back-to-back throughput: one request per 2 cycles for stores, READ_LATENCY+2 cycles for loads.
- Stores:
  - byte writes i_datawrite[7:0] into lane address[1:0];
  - half writes [15:0] into lanes {address[1],0} and {address[1],1};
  - word writes all lanes.
  - Other lanes are unchanged.
- Loads:
  - The selected lane(s) are shifted to the LSBs.
  - Upper bits are filled with the sign bit if i_signedmem=1, else zeros.
- i_req_valid outside IDLE is ignored. The requester must hold it until acceptance.
- Reset mid-operation:
  - A pending load is dropped and no response is issued.
  - A store already committed stays in RAM.

Optional Feature:
MEM_DEBUG_PORT_EN
- Defined: adds input i_dbg_addr (log2(DEPTH_WORDS) bits, word index) and output o_dbg_data (DATA_WIDTH).
  - o_dbg_data is a combinational read of the RAM word.
  - Available in every state; no effect on the handshake.
  - Intended for the debug unit to dump memory over UART.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset held low 3 cycles, released -> o_req_ready=1, o_resp_valid=0, o_stall=0, o_dataread=0.
- Store word 0xDEADBEEF @0x10, then load word @0x10 with READ_LATENCY=2 -> o_stall high 2 cycles; o_resp_valid 3 cycles after acceptance; o_dataread=0xDEADBEEF.
- Store byte 0x80 @0x13, then two loads -> signed byte @0x13 returns 0xFFFFFF80; unsigned returns 0x00000080; word @0x10 returns 0x80ADBEEF.
- Load half @0x12, signed -> 0xFFFF80AD. Load half @0x11 -> o_misaligned=1, o_dataread=0, no RAM change.
- Store word @0x10 + DEPTH_WORDS*4 -> wraps to word 4; load @0x10 returns the new value.
- Assert i_reset_n low during WAIT of a load -> no response pulse; the following load of the same address returns the stored data.
